bit_stream_serializer: RTL

//  Upstream feeder for the serial pattern detectors: accepts WIDTH-bit words over valid/ready
//  and emits them one bit per clk on ser_bit, gapless when words arrive back-to-back.

---
 rtl/bit_stream_serializer_if.sv | 25 ++
 rtl/bit_stream_serializer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out bus of the bit stream serializer.
// The master drives words and flush; the slave (the serializer) drives the serial side.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_active;
  logic             word_start;
  logic             word_done;
  logic [15:0]      words_sent;

  modport master (
    output flush, in_data, in_valid,
    input  in_ready, ser_bit, ser_active, word_start, word_done, words_sent
  );

  modport slave (
    input  flush, in_data, in_valid,
    output in_ready, ser_bit, ser_active, word_start, word_done, words_sent
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Double-buffered word serializer: a hold register takes the next word while the shift
// register sends the current one, so back-to-back words come out with no idle gap.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  bit_stream_serializer_if.slave ser_if
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_active_q, ser_active_d;
  logic             word_start_q, word_start_d;
  logic             word_done_q, word_done_d;
  logic [15:0]      words_sent_q, words_sent_d;

  logic             in_ready;
  logic             accept;
  logic             can_load;
  logic             load_hold;
  logic             load_bypass;
  logic             word_end;
  logic [WIDTH-1:0] load_word;

  // Ready depends only on state and flush, never on in_valid.
  assign in_ready    = !hold_full_q && !ser_if.flush;
  assign accept      = ser_if.in_valid && in_ready;
  // The shifter can take a new word when empty or on the last bit of the current word.
  assign can_load    = (state_q == StIdle) || (cnt_q == LastCnt);
  assign load_hold   = hold_full_q && can_load;
  assign load_bypass = !hold_full_q && accept && can_load;
  assign load_word   = load_hold ? hold_q : ser_if.in_data;
  // A flush on the last bit abandons the word, so it is not counted.
  assign word_end    = (state_q == StShift) && (cnt_q == LastCnt) && !ser_if.flush;

  // Next-state: hold buffer, shifter and the registered serial outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    ser_bit_d    = IDLE_BIT;
    ser_active_d = 1'b0;
    word_start_d = 1'b0;
    word_done_d  = 1'b0;
    words_sent_d = words_sent_q;

    if (word_end && (words_sent_q != 16'hFFFF)) begin
      words_sent_d = words_sent_q + 16'd1;
    end

    if (ser_if.flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else begin
      if (load_hold) begin
        hold_full_d = 1'b0;
      end
      if (accept && !load_bypass) begin
        hold_d      = ser_if.in_data;
        hold_full_d = 1'b1;
      end

      if (load_hold || load_bypass) begin
        state_d      = StShift;
        cnt_d        = '0;
        shift_d      = load_word;
        ser_bit_d    = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
        ser_active_d = 1'b1;
        word_start_d = 1'b1;
      end else if ((state_q == StShift) && (cnt_q != LastCnt)) begin
        cnt_d        = cnt_q + CntOne;
        shift_d      = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        ser_bit_d    = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        ser_active_d = 1'b1;
        word_done_d  = (cnt_d == LastCnt);
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  // State registers; reset abandons any word in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      ser_bit_q    <= IDLE_BIT;
      ser_active_q <= 1'b0;
      word_start_q <= 1'b0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      ser_bit_q    <= ser_bit_d;
      ser_active_q <= ser_active_d;
      word_start_q <= word_start_d;
      word_done_q  <= word_done_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign ser_if.in_ready   = in_ready;
  assign ser_if.ser_bit    = ser_bit_q;
  assign ser_if.ser_active = ser_active_q;
  assign ser_if.word_start = word_start_q;
  assign ser_if.word_done  = word_done_q;
  assign ser_if.words_sent = words_sent_q;

endmodule
